// File: rtl/ar_rr_sel21.sv
// ar_rr_sel21: two-channel round-robin arbiter driving the select line of a 2:1 mux stage.
// Optional hold timeout is compiled in with `define AR_SEL_TIMEOUT_EN.
module ar_rr_sel21 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       done_i,
    output logic       sel_o,
    output logic [1:0] grant_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

`ifdef AR_SEL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q;
    logic [1:0]       grant_q;
    logic             busy_q;

    logic owner;
    logic timeoutHit;
    logic releaseNow;
    logic idleWinner;

    assign owner      = (state_q == G1);
    assign timeoutHit = TIMEOUT_EN && (cnt_q == HOLD_LAST);
    assign releaseNow = done_i || !req_i[owner] || timeoutHit;
    // On a tie the channel that did not win last time gets the path.
    assign idleWinner = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = idleWinner ? G1 : G0;
                    last_d  = idleWinner;
                    cnt_d   = '0;
                end
            end
            G0, G1: begin
                if (!releaseNow) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (req_i[~owner]) begin
                    // Direct handoff: the other channel takes over without an idle bubble.
                    state_d = owner ? G0 : G1;
                    last_d  = ~owner;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change together with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (state_d == G0) begin
                sel_q <= 1'b0;
            end else if (state_d == G1) begin
                sel_q <= 1'b1;
            end
            grant_q <= {state_d == G1, state_d == G0};
            busy_q  <= (state_d != IDLE);
        end
    end

    assign sel_o   = sel_q;
    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_ar_rr_sel21.sv
// Scoreboard bench for ar_rr_sel21: directed scenarios plus random traffic against an ownership model.
// Define AR_SEL_TIMEOUT_EN for both bench and RTL to exercise the hold timeout.
module tb_ar_rr_sel21;

    localparam int HOLD_MAX = 8;
    localparam int CNT_W    = 4;

`ifdef AR_SEL_TIMEOUT_EN
    localparam bit timeoutOn = 1'b1;
`else
    localparam bit timeoutOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] req = 2'b00;
    logic       done = 1'b0;
    logic       sel;
    logic [1:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    ar_rr_sel21 #(
        .HOLD_MAX(HOLD_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req),
        .done_i (done),
        .sel_o  (sel),
        .grant_o(grant),
        .busy_o (busy)
    );

    typedef struct {
        logic       expSel;
        logic [1:0] expGrant;
        logic       expBusy;
        string      tag;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Model: who owns the path (-1 = nobody), who won last, how many cycles the owner has held it.
    int   owner;
    int   lastIdx;
    int   held;
    logic modelSel;

    function automatic void modelReset();
        owner    = -1;
        lastIdx  = 1;
        held     = 0;
        modelSel = 1'b0;
    endfunction

    function automatic void modelStep(input logic [1:0] r, input logic d);
        int  other;
        bit  rel;
        if (owner < 0) begin
            if (r == 2'b11)  owner = 1 - lastIdx;
            else if (r[0])   owner = 0;
            else if (r[1])   owner = 1;
            if (owner >= 0) begin
                lastIdx = owner;
                held    = 1;
            end
        end else begin
            rel = d || !r[owner] || (timeoutOn && held >= HOLD_MAX);
            if (!rel) begin
                held++;
            end else begin
                other = 1 - owner;
                if (r[other]) begin
                    owner   = other;
                    lastIdx = other;
                    held    = 1;
                end else begin
                    owner = -1;
                end
            end
        end
        if (owner >= 0) modelSel = (owner == 1);
    endfunction

    task automatic checkOutput(input string name, input logic eSel, input logic [1:0] eGrant,
                               input logic eBusy);
        compared++;
        if (sel !== eSel || grant !== eGrant || busy !== eBusy) begin
            mismatched++;
            $display("[TB] FAIL %s: got sel=%b grant=%b busy=%b, expected sel=%b grant=%b busy=%b",
                     name, sel, grant, busy, eSel, eGrant, eBusy);
        end
    endtask

    // Drive one cycle of inputs from the negative edge and queue the response expected after the next rising edge.
    task automatic applyStimulus(input logic [1:0] r, input logic d, input string tag);
        exp_t e;
        req  = r;
        done = d;
        modelStep(r, d);
        e.expSel   = modelSel;
        e.expGrant = (owner < 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
        e.expBusy  = (owner >= 0);
        e.tag      = tag;
        expQ.push_back(e);
        @(negedge clk);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.tag, e.expSel, e.expGrant, e.expBusy);
        end
    end

    initial begin
        modelReset();
        #1;
        rst  = 1'b1;
        req  = 2'b11;
        done = 1'b0;
        #2;
        checkOutput("reset_async", 1'b0, 2'b00, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #2;
            checkOutput("reset_held", 1'b0, 2'b00, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 1'b0, "first_tie");

        for (int i = 0; i < 2; i++) applyStimulus(2'b00, 1'b0, "to_idle");
        for (int i = 0; i < 3; i++) applyStimulus(2'b10, 1'b0, "single_owner");
        applyStimulus(2'b10, 1'b1, "single_done");
        applyStimulus(2'b00, 1'b0, "idle_keep_sel");
        applyStimulus(2'b00, 1'b1, "done_in_idle");

        for (int i = 0; i < 8; i++) applyStimulus(2'b11, (i % 2) == 1, "fair_handoff");
        for (int i = 0; i < 2; i++) applyStimulus(2'b00, 1'b0, "to_idle");

        applyStimulus(2'b01, 1'b0, "drop_g0");
        applyStimulus(2'b01, 1'b0, "drop_g0");
        applyStimulus(2'b10, 1'b0, "drop_handoff");
        applyStimulus(2'b00, 1'b0, "to_idle");

        for (int i = 0; i < 20; i++) applyStimulus(2'b11, 1'b0, "long_hold");
        for (int i = 0; i < 2; i++) applyStimulus(2'b00, 1'b0, "to_idle");
        for (int i = 0; i < 12; i++) applyStimulus(2'b01, 1'b0, "long_single");
        applyStimulus(2'b00, 1'b0, "to_idle");

        // Mid-grant asynchronous reset while channel 1 owns the path.
        applyStimulus(2'b10, 1'b0, "enter_g1");
        @(posedge clk);
        #2;
        checkOutput("pre_reset_g1", 1'b1, 2'b10, 1'b1);
        #1;
        rst = 1'b1;
        req = 2'b11;
        #1;
        checkOutput("mid_reset", 1'b0, 2'b00, 1'b0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 1'b0, "post_reset_tie");

        for (int i = 0; i < 400; i++) begin
            logic [1:0] r;
            logic       d;
            r = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0);
            applyStimulus(r, d, "random");
        end
        applyStimulus(2'b00, 1'b0, "final_idle");

        for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
